// File: rtl/jesd204b_lmfc_sync.sv
// rtl/jesd204b_lmfc_sync.sv - LMFC generator with SYSREF realignment, lock qualification and phase-error reporting
// Define JESD204B_LMFC_SYNC_ERR_CNT_EN to build the saturating misaligned-edge counter.
module jesd204b_lmfc_sync #(
  parameter int JESD_F         = 1,
  parameter int JESD_K         = 32,
  parameter int BYTES_PER_CLK  = 4,
  parameter int LMFC_CNT_WIDTH = 8,
  parameter int LOCK_COUNT     = 2,
  localparam int P             = JESD_K * JESD_F / BYTES_PER_CLK,
  localparam int PW            = (P < 2) ? 1 : $clog2(P)
) (
  input  logic                      dclk,
  input  logic                      rst,
  input  logic                      sysref,
  input  logic                      i_continuous,
  input  logic                      i_arm,
  output logic                      o_lmfc,
  output logic [PW-1:0]             o_lmfc_phase,
  output logic [LMFC_CNT_WIDTH-1:0] o_lmfc_cnt,
  output logic                      o_locked,
  output logic                      o_sysref_done,
  output logic                      o_sysref_err,
  output logic [7:0]                o_sysref_err_cnt
);

  if ((JESD_K * JESD_F) % BYTES_PER_CLK != 0) begin : g_bad_ratio
    $error("JESD_K*JESD_F must be a multiple of BYTES_PER_CLK");
  end
  if (P < 2) begin : g_bad_period
    $error("LMFC period must be at least 2 dclk cycles");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
    $error("LOCK_COUNT must be in 1..15");
  end

  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [3:0]    LOCK_N = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {ARMED, ALIGN, LOCKED} state_t;

  state_t                    state;
  logic                      s1;
  logic                      s2;
  logic                      edge_q;
  logic [PW-1:0]             phase;
  logic [LMFC_CNT_WIDTH-1:0] lmfc_cnt;
  logic [3:0]                good_cnt;
  logic                      aligned;
  logic                      err_event;

  // The edge detect is registered, giving a fixed two-cycle pin-to-boundary latency.
  assign aligned   = (phase == P_LAST);
  assign err_event = ~i_arm & edge_q & ~aligned & (state != ARMED);

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      edge_q        <= 1'b0;
      phase         <= '0;
      lmfc_cnt      <= '0;
      good_cnt      <= 4'd0;
      state         <= ARMED;
      o_locked      <= 1'b0;
      o_sysref_done <= 1'b0;
      o_sysref_err  <= 1'b0;
    end else begin
      s1            <= sysref;
      s2            <= s1;
      edge_q        <= s1 & ~s2;
      o_sysref_done <= 1'b0;
      o_sysref_err  <= err_event;

      phase <= aligned ? '0 : phase + 1'b1;
      if (aligned) begin
        lmfc_cnt <= lmfc_cnt + 1'b1;
      end

      if (i_arm) begin
        state    <= ARMED;
        good_cnt <= 4'd0;
        o_locked <= 1'b0;
      end else if (edge_q) begin
        case (state)
          ARMED: begin
            phase         <= '0;
            lmfc_cnt      <= '0;
            o_sysref_done <= 1'b1;
            good_cnt      <= 4'd0;
            state         <= ALIGN;
          end
          ALIGN: begin
            if (aligned) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LOCK_N) begin
                state    <= LOCKED;
                o_locked <= 1'b1;
              end
            end else begin
              phase         <= '0;
              lmfc_cnt      <= '0;
              o_sysref_done <= 1'b1;
              good_cnt      <= 4'd0;
            end
          end
          LOCKED: begin
            // One-shot mode keeps the established phase and only reports the error.
            if (!aligned && i_continuous) begin
              phase         <= '0;
              lmfc_cnt      <= '0;
              o_sysref_done <= 1'b1;
              good_cnt      <= 4'd0;
              state         <= ALIGN;
              o_locked      <= 1'b0;
            end
          end
          default: begin
            state    <= ARMED;
            good_cnt <= 4'd0;
            o_locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef JESD204B_LMFC_SYNC_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err_event && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign o_sysref_err_cnt = err_cnt;
`else
  assign o_sysref_err_cnt = 8'd0;
`endif

  assign o_lmfc       = (phase == '0);
  assign o_lmfc_phase = phase;
  assign o_lmfc_cnt   = lmfc_cnt;

endmodule

// File: tb/tb_jesd204b_lmfc_sync.sv
// tb/tb_jesd204b_lmfc_sync.sv - directed table-driven bench for jesd204b_lmfc_sync (K=32, F=1, 4 octets/clk, P=8)
module tb_jesd204b_lmfc_sync;

  logic       dclk = 1'b0;
  logic       rst = 1'b1;
  logic       sysref = 1'b0;
  logic       i_continuous = 1'b1;
  logic       i_arm = 1'b0;
  logic       o_lmfc;
  logic [2:0] o_lmfc_phase;
  logic [7:0] o_lmfc_cnt;
  logic       o_locked;
  logic       o_sysref_done;
  logic       o_sysref_err;
  logic [7:0] o_sysref_err_cnt;

  int checks = 0;
  int errors = 0;

  jesd204b_lmfc_sync dut (
    .dclk             (dclk),
    .rst              (rst),
    .sysref           (sysref),
    .i_continuous     (i_continuous),
    .i_arm            (i_arm),
    .o_lmfc           (o_lmfc),
    .o_lmfc_phase     (o_lmfc_phase),
    .o_lmfc_cnt       (o_lmfc_cnt),
    .o_locked         (o_locked),
    .o_sysref_done    (o_sysref_done),
    .o_sysref_err     (o_sysref_err),
    .o_sysref_err_cnt (o_sysref_err_cnt)
  );

  always #5 dclk = ~dclk;

  typedef struct {
    int idle;
    bit cont;
    bit arm;
    int ph;
    int cnt;
    bit done;
    bit err;
    bit lock;
    int ec;
  } vec_t;

  vec_t tbl[10];

  function automatic int ec_exp(input int v);
`ifdef JESD204B_LMFC_SYNC_ERR_CNT_EN
    return (v > 255) ? 255 : v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic step();
    @(posedge dclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Raise sysref for one cycle; returns at the cycle where the resulting action is visible.
  task automatic pulse(input bit arm_at_detect);
    sysref = 1'b1;
    step();
    sysref = 1'b0;
    step();
    if (arm_at_detect) i_arm = 1'b1;
    step();
    i_arm = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, int'(o_lmfc_phase), 0);
    chk({tag, "_lmfc"}, int'(o_lmfc), 1);
    chk({tag, "_cnt"}, int'(o_lmfc_cnt), 0);
    chk({tag, "_locked"}, int'(o_locked), 0);
    chk({tag, "_done"}, int'(o_sysref_done), 0);
    chk({tag, "_err"}, int'(o_sysref_err), 0);
    chk({tag, "_errcnt"}, int'(o_sysref_err_cnt), 0);
  endtask

  initial begin
    int n_done;
    int n_err;

    //           idle cont arm ph cnt done err lock ec
    tbl[0] = '{ 0, 1'b1, 1'b0, 0,  0, 1'b1, 1'b0, 1'b0, 0};
    tbl[1] = '{61, 1'b1, 1'b0, 0,  8, 1'b0, 1'b0, 1'b0, 0};
    tbl[2] = '{61, 1'b1, 1'b0, 0, 16, 1'b0, 1'b0, 1'b1, 0};
    tbl[3] = '{64, 1'b1, 1'b0, 0,  0, 1'b1, 1'b1, 1'b0, 1};
    tbl[4] = '{61, 1'b1, 1'b0, 0,  8, 1'b0, 1'b0, 1'b0, 1};
    tbl[5] = '{61, 1'b1, 1'b0, 0, 16, 1'b0, 1'b0, 1'b1, 1};
    tbl[6] = '{64, 1'b0, 1'b0, 3, 24, 1'b0, 1'b1, 1'b1, 2};
    tbl[7] = '{ 1, 1'b0, 1'b1, 7, 24, 1'b0, 1'b0, 1'b0, 2};
    tbl[8] = '{ 0, 1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 1'b0, 2};
    tbl[9] = '{ 2, 1'b0, 1'b0, 0,  0, 1'b1, 1'b1, 1'b0, 3};

    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;

    for (int k = 1; k <= 20; k++) begin
      step();
      chk("free_phase", int'(o_lmfc_phase), k % 8);
      chk("free_lmfc", int'(o_lmfc), (k % 8 == 0) ? 1 : 0);
      chk("free_cnt", int'(o_lmfc_cnt), k / 8);
      chk("free_locked", int'(o_locked), 0);
    end

    for (int i = 0; i < 10; i++) begin
      i_continuous = tbl[i].cont;
      repeat (tbl[i].idle) step();
      pulse(tbl[i].arm);
      chk($sformatf("v%0d_phase", i), int'(o_lmfc_phase), tbl[i].ph);
      chk($sformatf("v%0d_lmfc", i), int'(o_lmfc), (tbl[i].ph == 0) ? 1 : 0);
      chk($sformatf("v%0d_cnt", i), int'(o_lmfc_cnt), tbl[i].cnt);
      chk($sformatf("v%0d_done", i), int'(o_sysref_done), int'(tbl[i].done));
      chk($sformatf("v%0d_err", i), int'(o_sysref_err), int'(tbl[i].err));
      chk($sformatf("v%0d_locked", i), int'(o_locked), int'(tbl[i].lock));
      chk($sformatf("v%0d_errcnt", i), int'(o_sysref_err_cnt), ec_exp(tbl[i].ec));
    end

    // A held-high sysref must give exactly one realignment.
    n_done = 0;
    n_err = 0;
    sysref = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (k == 20) sysref = 1'b0;
      step();
      n_done += int'(o_sysref_done);
      n_err += int'(o_sysref_err);
    end
    chk("hold_done_pulses", n_done, 1);
    chk("hold_err_pulses", n_err, 1);
    chk("hold_errcnt", int'(o_sysref_err_cnt), ec_exp(4));
    chk("hold_phase", int'(o_lmfc_phase), 6);

    n_err = 0;
    for (int k = 0; k < 300; k++) begin
      pulse(1'b0);
      n_err += int'(o_sysref_err);
    end
    chk("sat_err_pulses", n_err, 300);
    chk("sat_errcnt", int'(o_sysref_err_cnt), ec_exp(304));

    // Asynchronous reset between clock edges.
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    step();
    rst = 1'b0;
    step();
    chk("rel_phase", int'(o_lmfc_phase), 1);
    chk("rel_cnt", int'(o_lmfc_cnt), 0);
    repeat (7) step();
    chk("rel_wrap_phase", int'(o_lmfc_phase), 0);
    chk("rel_wrap_lmfc", int'(o_lmfc), 1);
    chk("rel_wrap_cnt", int'(o_lmfc_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jesd204b_lmfc_sync.md
# jesd204b_lmfc_sync

Parametrised LMFC generator and SYSREF alignment monitor for the JESD204B receive path. It derives a free-running local multiframe clock from the device clock and realigns it deterministically to SYSREF rising edges. It qualifies alignment over several SYSREF edges before declaring lock, and reports later phase errors. It sits between the transceiver clock buffer / SYSREF input pin and the lane alignment logic that consumes the LMFC boundary and multiframe count.

## Interface
- JESD_F, 1, octets per frame.
- JESD_K, 32, frames per multiframe.
- BYTES_PER_CLK, 4, octets per lane per dclk cycle.
- LMFC_CNT_WIDTH, 8, width of multiframe counter.
- LOCK_COUNT, 2, consecutive aligned SYSREF edges required for lock (1..15).
- Derived: P = JESD_K*JESD_F/BYTES_PER_CLK, the LMFC period in dclk cycles. PW = $clog2(P).

Ports:
- dclk  in  1  device clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- sysref  in  1  SYSREF, already synchronous to dclk.
- i_continuous  in  1  1 = realign on every misaligned edge; 0 = one-shot (realign only while not locked).
- i_arm  in  1  single-cycle pulse that restarts the acquisition.
- o_lmfc  out  1  high during the cycle where the phase equals 0 (the LMFC boundary).
- o_lmfc_phase  out  PW  phase within the multiframe, 0..P-1.
- o_lmfc_cnt  out  LMFC_CNT_WIDTH  multiframe counter.
- o_locked  out  1  high in the LOCKED state.
- o_sysref_done  out  1  one-cycle pulse on each realignment.
- o_sysref_err  out  1  one-cycle pulse on each misaligned SYSREF edge.
- o_sysref_err_cnt  out  8  saturating count of misaligned edges.

## Operation
- Elaboration must fail if JESD_K*JESD_F is not a multiple of BYTES_PER_CLK, or if P < 2.
- SYSREF handling:
  - sysref is registered twice: s1, then s2.
  - A rising edge is detected as edge = s1 & ~s2.
  - A level held high produces exactly one edge.
- Free-running counters:
  - phase increments every cycle and wraps from P-1 to 0.
  - o_lmfc_cnt increments on the P-1 to 0 wrap and wraps modulo 2^LMFC_CNT_WIDTH.
- Realignment: phase and o_lmfc_cnt are both set to 0 on the next cycle, and o_sysref_done pulses in that same cycle.
- An edge is aligned when it occurs with phase == P-1, i.e. the free-running wrap coincides with the edge. Any other phase is misaligned.
- State machine, states ARMED, ALIGN, LOCKED:
  - ARMED:
    - edge → realign; good count = 0; go to ALIGN.
    - No error is flagged in this state.
  - ALIGN:
    - aligned edge → good count +1.
    - When the good count reaches LOCK_COUNT → go to LOCKED.
    - misaligned edge → realign; good count = 0; o_sysref_err pulses; stay in ALIGN.
  - LOCKED:
    - aligned edge → no action.
    - misaligned edge → o_sysref_err pulses.
      - If i_continuous = 1: realign and go to ALIGN with good count = 0.
      - If i_continuous = 0: keep phase and stay LOCKED.
- i_arm in any state → ARMED, good count cleared. The error count is not cleared by i_arm.
- If i_arm and edge occur in the same cycle, i_arm wins and that edge is ignored.
- o_sysref_err_cnt saturates at 255.

## Timing
- Reset values:
  - phase = 0, so o_lmfc = 1; o_lmfc_cnt = 0.
  - o_locked = 0, o_sysref_done = 0, o_sysref_err = 0, o_sysref_err_cnt = 0.
  - State = ARMED, s1 = s2 = 0.
- If sysref rises before dclk edge N, then:
  - s1 = 1 after edge N.
  - edge is seen during cycle N+1.
  - phase = 0, o_lmfc = 1 and o_sysref_done = 1 after edge N+2.
  - Fixed latency: 2 cycles from pin to boundary.
- o_sysref_err and the state change follow the detection cycle by 1 cycle.
- o_locked rises 1 cycle after the LOCK_COUNT-th aligned edge is detected.
- Outputs are registered; o_lmfc is decoded from the phase register only.
- rst asserted mid-operation forces the reset values immediately. Counting restarts on the first dclk after rst is released.

## Configuration
- Macro JESD204B_LMFC_SYNC_ERR_CNT_EN.
- Defined: the 8-bit saturating error counter is implemented.
- Undefined: no counter register; o_sysref_err_cnt is tied to 0, while o_sysref_err still pulses.

## Test plan
All scenarios use K=32, F=1, BYTES_PER_CLK=4 (P=8) and LOCK_COUNT=2.
- Reset release, no sysref → phase counts 0..7 repeatedly; o_lmfc is high every 8th cycle; o_lmfc_cnt increments once per 8 cycles; o_locked stays 0.
- sysref pulse at arbitrary phase → o_sysref_done and phase=0 exactly 2 cycles later; o_lmfc_cnt = 0; state ALIGN.
- Two further pulses spaced 64 cycles after the first realignment → no errors; o_locked = 1 one cycle after the second edge is detected.
- Locked with i_continuous=1, pulse displaced by +3 cycles → o_sysref_err pulses; o_sysref_err_cnt = 1; realign; o_locked falls. With i_continuous=0 instead, the phase is unchanged and o_locked stays 1.
- i_arm in the same cycle as a detected edge → state ARMED, no realignment. The next edge realigns.
- 300 misaligned edges with the macro defined → o_sysref_err_cnt = 255. With the macro undefined → count = 0.
